// File: rtl/rob_commit_unit.sv
// 3-wide in-order reorder buffer: allocates in program order, accepts out-of-order
// writebacks, and retires up to three entries per cycle onto the register-file write ports.
module rob_commit_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 16,
    parameter int IDX_WIDTH  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  alloc_valid_0,
    input  logic                  alloc_valid_1,
    input  logic                  alloc_valid_2,
    input  logic                  alloc_has_dest_0,
    input  logic                  alloc_has_dest_1,
    input  logic                  alloc_has_dest_2,
    input  logic [ADDR_WIDTH-1:0] alloc_dest_addr_0,
    input  logic [ADDR_WIDTH-1:0] alloc_dest_addr_1,
    input  logic [ADDR_WIDTH-1:0] alloc_dest_addr_2,
    output logic                  alloc_ready,
    output logic [IDX_WIDTH-1:0]  alloc_idx_0,
    output logic [IDX_WIDTH-1:0]  alloc_idx_1,
    output logic [IDX_WIDTH-1:0]  alloc_idx_2,
    input  logic                  wb_valid_0,
    input  logic                  wb_valid_1,
    input  logic                  wb_valid_2,
    input  logic [IDX_WIDTH-1:0]  wb_idx_0,
    input  logic [IDX_WIDTH-1:0]  wb_idx_1,
    input  logic [IDX_WIDTH-1:0]  wb_idx_2,
    input  logic [DATA_WIDTH-1:0] wb_data_0,
    input  logic [DATA_WIDTH-1:0] wb_data_1,
    input  logic [DATA_WIDTH-1:0] wb_data_2,
    output logic                  commit_enable_0,
    output logic                  commit_enable_1,
    output logic                  commit_enable_2,
    output logic [ADDR_WIDTH-1:0] commit_addr_0,
    output logic [ADDR_WIDTH-1:0] commit_addr_1,
    output logic [ADDR_WIDTH-1:0] commit_addr_2,
    output logic [DATA_WIDTH-1:0] commit_data_0,
    output logic [DATA_WIDTH-1:0] commit_data_1,
    output logic [DATA_WIDTH-1:0] commit_data_2,
    output logic [IDX_WIDTH:0]    rob_count,
    output logic                  rob_empty
);
    localparam int NW    = 3;
    localparam int CNT_W = IDX_WIDTH + 1;

    logic [DEPTH-1:0]      r_valid;
    logic [DEPTH-1:0]      r_done;
    logic [DEPTH-1:0]      r_has_dest;
    logic [ADDR_WIDTH-1:0] r_dest [DEPTH];
    logic [DATA_WIDTH-1:0] r_data [DEPTH];
    logic [IDX_WIDTH-1:0]  r_head;
    logic [IDX_WIDTH-1:0]  r_tail;
    logic [CNT_W-1:0]      r_count;

    logic [NW-1:0]                 r_commit_en;
    logic [NW-1:0][ADDR_WIDTH-1:0] r_commit_addr;
    logic [NW-1:0][DATA_WIDTH-1:0] r_commit_data;

    logic [NW-1:0]                 w_alloc_valid;
    logic [NW-1:0]                 w_alloc_has_dest;
    logic [NW-1:0][ADDR_WIDTH-1:0] w_alloc_dest;
    logic [NW-1:0]                 w_wb_valid;
    logic [NW-1:0][IDX_WIDTH-1:0]  w_wb_idx;
    logic [NW-1:0][DATA_WIDTH-1:0] w_wb_data;
    logic [NW-1:0][IDX_WIDTH-1:0]  w_alloc_slot;
    logic [NW-1:0][IDX_WIDTH-1:0]  w_head_slot;
    logic [NW-1:0]                 w_alloc_en;
    logic [NW-1:0]                 w_writes;
    logic [NW-1:0]                 w_elig;
    logic                          w_chain;
    logic                          w_ok;
    logic [1:0]                    w_n_alloc;
    logic [1:0]                    w_n_commit;

    assign w_alloc_valid    = {alloc_valid_2, alloc_valid_1, alloc_valid_0};
    assign w_alloc_has_dest = {alloc_has_dest_2, alloc_has_dest_1, alloc_has_dest_0};
    assign w_alloc_dest     = {alloc_dest_addr_2, alloc_dest_addr_1, alloc_dest_addr_0};
    assign w_wb_valid       = {wb_valid_2, wb_valid_1, wb_valid_0};
    assign w_wb_idx         = {wb_idx_2, wb_idx_1, wb_idx_0};
    assign w_wb_data        = {wb_data_2, wb_data_1, wb_data_0};

    assign alloc_ready = (r_count <= CNT_W'(DEPTH - 3));
    assign rob_empty   = (r_count == '0);
    assign rob_count   = r_count;

    genvar gi;
    generate
        for (gi = 0; gi < NW; gi++) begin : g_slot
            assign w_alloc_slot[gi] = r_tail + IDX_WIDTH'(gi);
            assign w_head_slot[gi]  = r_head + IDX_WIDTH'(gi);
            assign w_alloc_en[gi]   = alloc_ready && w_alloc_valid[gi];
            // Only real register writes (nonzero address) take part in collision checks.
            assign w_writes[gi]     = r_has_dest[w_head_slot[gi]] && (r_dest[w_head_slot[gi]] != '0);
        end
    endgenerate

    assign alloc_idx_0 = w_alloc_slot[0];
    assign alloc_idx_1 = w_alloc_slot[1];
    assign alloc_idx_2 = w_alloc_slot[2];

    always_comb begin
        w_n_alloc = '0;
        for (int k = 0; k < NW; k++) begin
            if (w_alloc_en[k]) w_n_alloc = w_n_alloc + 2'd1;
        end
    end

    // Selection stops at the first slot that is not done or would collide with an earlier write.
    always_comb begin
        w_chain    = 1'b1;
        w_ok       = 1'b0;
        w_elig     = '0;
        w_n_commit = '0;
        for (int k = 0; k < NW; k++) begin
            w_ok = w_chain && (CNT_W'(k) < r_count) && r_done[w_head_slot[k]];
            for (int j = 0; j < k; j++) begin
                if (w_writes[j] && w_writes[k] &&
                    (r_dest[w_head_slot[j]] == r_dest[w_head_slot[k]])) w_ok = 1'b0;
            end
            w_elig[k] = w_ok;
            w_chain   = w_ok;
            if (w_ok) w_n_commit = w_n_commit + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid       <= '0;
            r_done        <= '0;
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_commit_en   <= '0;
            r_commit_addr <= '0;
            r_commit_data <= '0;
        end else if (flush) begin
            r_valid     <= '0;
            r_done      <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_commit_en <= '0;
        end else begin
            for (int p = 0; p < NW; p++) begin
                if (w_wb_valid[p] && r_valid[w_wb_idx[p]]) r_done[w_wb_idx[p]] <= 1'b1;
            end
            for (int k = 0; k < NW; k++) begin
                if (w_elig[k]) begin
                    r_valid[w_head_slot[k]] <= 1'b0;
                    r_commit_en[k]          <= w_writes[k];
                    r_commit_addr[k]        <= r_dest[w_head_slot[k]];
                    r_commit_data[k]        <= r_data[w_head_slot[k]];
                end else begin
                    r_commit_en[k] <= 1'b0;
                end
            end
            for (int k = 0; k < NW; k++) begin
                if (w_alloc_en[k]) begin
                    r_valid[w_alloc_slot[k]] <= 1'b1;
                    r_done[w_alloc_slot[k]]  <= 1'b0;
                end
            end
            r_head  <= r_head + IDX_WIDTH'(w_n_commit);
            r_tail  <= r_tail + IDX_WIDTH'(w_n_alloc);
            r_count <= r_count + CNT_W'(w_n_alloc) - CNT_W'(w_n_commit);
        end
    end

    // Payload storage needs no reset: it is only read behind a valid/done entry.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NW; p++) begin
            if (w_wb_valid[p] && r_valid[w_wb_idx[p]]) r_data[w_wb_idx[p]] <= w_wb_data[p];
        end
        for (int k = 0; k < NW; k++) begin
            if (w_alloc_en[k]) begin
                r_has_dest[w_alloc_slot[k]] <= w_alloc_has_dest[k];
                r_dest[w_alloc_slot[k]]     <= w_alloc_dest[k];
            end
        end
    end

    assign commit_enable_0 = r_commit_en[0];
    assign commit_enable_1 = r_commit_en[1];
    assign commit_enable_2 = r_commit_en[2];
    assign commit_addr_0   = r_commit_addr[0];
    assign commit_addr_1   = r_commit_addr[1];
    assign commit_addr_2   = r_commit_addr[2];
    assign commit_data_0   = r_commit_data[0];
    assign commit_data_1   = r_commit_data[1];
    assign commit_data_2   = r_commit_data[2];

endmodule
